// File: rtl/video_ctx_pkg.sv
// Shared types for the skin-detection front end: FSM states, default geometry
// widths and the per-pixel context vector carried through the del_x_x delay lines.
package video_ctx_pkg;

  localparam int X_BITS_DEF = 11;
  localparam int Y_BITS_DEF = 11;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic                  de;
    logic                  h_sync;
    logic                  v_sync;
    logic                  sof;
    logic                  eol;
    logic                  eof;
    logic [X_BITS_DEF-1:0] x;
    logic [Y_BITS_DEF-1:0] y;
  } ctx_t;

endpackage

// File: rtl/edge_det.sv
// Registered edge detector: q is d delayed one ce cycle; pulse flags the
// selected edge (rising by default, falling when fall_edge=1) combinationally.
module edge_det #(
  parameter bit fall_edge = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q,
  output logic pulse
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ce) begin
      q <= d;
    end
  end

  assign pulse = fall_edge ? (~d & q) : (d & ~q);

endmodule

// File: rtl/video_ctx_tracker.sv
// Video context tracker: registers the stream and derives x/y, sof/eol/eof, geometry, line-length error.
// 1 ce cycle latency on every output; ce=0 stalls all state. Optional VIDEO_CTX_FRAME_CNT_EN adds frame_cnt_o.
module video_ctx_tracker
  import video_ctx_pkg::*;
#(
  parameter int width  = 24,
  parameter int x_bits = X_BITS_DEF,
  parameter int y_bits = Y_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [width-1:0]  pixel_i,
  input  logic              de_i,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  output logic [width-1:0]  pixel_o,
  output logic              de_o,
  output logic              h_sync_o,
  output logic              v_sync_o,
  output logic [x_bits-1:0] x_o,
  output logic [y_bits-1:0] y_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              eof_o,
  output logic              valid_o,
  output logic [x_bits-1:0] frame_w_o,
  output logic [y_bits-1:0] frame_h_o,
  output logic              err_o
`ifdef VIDEO_CTX_FRAME_CNT_EN
  , output logic [15:0]     frame_cnt_o
`endif
);

  state_t            state, state_nxt;
  logic              v_rise, de_fall, de_rise;
  logic              in_frame, frame_act, line_end, eof_now;
  logic [x_bits-1:0] x_cnt, ref_w, refw_cl;
  logic [y_bits-1:0] y_cnt, y_cl;
  logic              have_ref, err_cl, geom_err;

  edge_det #(.fall_edge(1'b0)) u_v_edge (
    .clk(clk), .rst(rst), .ce(ce), .d(v_sync_i), .q(v_sync_o), .pulse(v_rise)
  );

  edge_det #(.fall_edge(1'b1)) u_de_edge (
    .clk(clk), .rst(rst), .ce(ce), .d(de_i), .q(de_o), .pulse(de_fall)
  );

  assign de_rise   = de_i & ~de_o;
  assign in_frame  = (state == ST_FRAME);
  assign frame_act = in_frame | v_rise;
  assign line_end  = in_frame & de_fall;
  assign eof_now   = in_frame & v_rise;
  assign valid_o   = in_frame;

  // A line ending on the v_sync edge is counted and checked before the frame closes.
  assign y_cl    = (line_end && !(&y_cnt)) ? y_cnt + 1'b1 : y_cnt;
  assign refw_cl = (line_end && !have_ref) ? x_cnt : ref_w;
  assign err_cl  = err_o | (line_end & have_ref & (x_cnt != ref_w));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (v_rise) begin
      state_nxt = ST_FRAME;
    end
  end

`ifdef VIDEO_CTX_FRAME_CNT_EN
  logic [x_bits-1:0] prev_w;
  logic [y_bits-1:0] prev_h;
  logic              have_prev;

  assign geom_err = eof_now & have_prev & ((refw_cl != prev_w) | (y_cl != prev_h));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
      prev_w      <= '0;
      prev_h      <= '0;
      have_prev   <= 1'b0;
    end else if (ce && eof_now) begin
      frame_cnt_o <= frame_cnt_o + 16'd1;
      prev_w      <= refw_cl;
      prev_h      <= y_cl;
      have_prev   <= 1'b1;
    end
  end
`else
  assign geom_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_o   <= '0;
      h_sync_o  <= 1'b0;
      x_o       <= '0;
      y_o       <= '0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
      eof_o     <= 1'b0;
      frame_w_o <= '0;
      frame_h_o <= '0;
      err_o     <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      ref_w     <= '0;
      have_ref  <= 1'b0;
    end else if (ce) begin
      pixel_o  <= pixel_i;
      h_sync_o <= h_sync_i;
      x_o      <= (frame_act && de_i) ? (v_rise ? '0 : x_cnt) : '0;
      y_o      <= (frame_act && de_i) ? (v_rise ? '0 : y_cnt) : '0;
      sof_o    <= de_rise & frame_act & (v_rise | (y_cnt == '0));
      eol_o    <= line_end;
      eof_o    <= eof_now;
      if (eof_now) begin
        frame_w_o <= refw_cl;
        frame_h_o <= y_cl;
      end
      if (v_rise) begin
        // A pixel arriving with the v_sync edge is already x=0 of the new frame.
        x_cnt    <= {{(x_bits-1){1'b0}}, de_i};
        y_cnt    <= '0;
        ref_w    <= '0;
        have_ref <= 1'b0;
        err_o    <= geom_err;
      end else if (in_frame) begin
        if (de_fall) begin
          x_cnt <= '0;
        end else if (de_i && !(&x_cnt)) begin
          x_cnt <= x_cnt + 1'b1;
        end
        y_cnt    <= y_cl;
        ref_w    <= refw_cl;
        have_ref <= have_ref | de_fall;
        err_o    <= err_cl;
      end
    end
  end

endmodule

// File: tb/tb_video_ctx_tracker.sv
// Randomized scoreboard bench for video_ctx_tracker against a line-list reference model.
module tb_video_ctx_tracker;

`ifdef VIDEO_CTX_FRAME_CNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [23:0] pixel_i = '0;
  logic        de_i = 1'b0;
  logic        h_sync_i = 1'b0;
  logic        v_sync_i = 1'b0;
  logic [23:0] pixel_o;
  logic        de_o, h_sync_o, v_sync_o, sof_o, eol_o, eof_o, valid_o, err_o;
  logic [10:0] x_o, frame_w_o;
  logic [10:0] y_o, frame_h_o;
`ifdef VIDEO_CTX_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  always #5 clk = ~clk;

  video_ctx_tracker dut (
    .clk(clk), .rst(rst), .ce(ce), .pixel_i(pixel_i), .de_i(de_i),
    .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .pixel_o(pixel_o), .de_o(de_o),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .x_o(x_o), .y_o(y_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .valid_o(valid_o),
    .frame_w_o(frame_w_o), .frame_h_o(frame_h_o), .err_o(err_o)
`ifdef VIDEO_CTX_FRAME_CNT_EN
    , .frame_cnt_o(frame_cnt_o)
`endif
  );

  typedef struct {
    int pix;
    bit de, hs, vs, sof, eol, eof, valid, err;
    int x, y, fw, fh, fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   jitter = 1'b0;

  // Reference model state: the frame is a list of completed line lengths.
  exp_t cur;
  bit   in_frame;
  int   run;
  int   lines[$];
  bit   geo_err, have_prev;
  int   pw, ph;

  function automatic bit lines_differ();
    for (int i = 1; i < lines.size(); i++)
      if (lines[i] != lines[0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    cur = '{default: 0};
    in_frame = 0; run = 0; lines.delete();
    geo_err = 0; have_prev = 0; pw = 0; ph = 0;
  endtask

  task automatic model_step(input bit r, input bit c, input int p, input bit d, input bit h, input bit v);
    bit vr, df, dr, was, geo;
    if (r) begin
      model_reset();
    end else if (c) begin
      vr  = v && !cur.vs;
      df  = !d && cur.de;
      dr  = d && !cur.de;
      was = in_frame;
      geo = 0;
      cur.eol = was && df;
      if (cur.eol) begin
        lines.push_back(run);
        run = 0;
      end
      cur.eof = was && vr;
      if (cur.eof) begin
        cur.fw = (lines.size() > 0) ? lines[0] : 0;
        cur.fh = lines.size();
        if (FEAT) begin
          geo = have_prev && (cur.fw != pw || cur.fh != ph);
          pw = cur.fw; ph = cur.fh; have_prev = 1;
          cur.fcnt = (cur.fcnt + 1) & 16'hffff;
        end
      end
      if (vr) begin
        geo_err = geo;
        in_frame = 1;
        lines.delete();
        run = 0;
      end
      if (in_frame && d) begin
        cur.x = run;
        cur.y = lines.size();
        cur.sof = dr && lines.size() == 0;
        run++;
      end else begin
        cur.x = 0; cur.y = 0; cur.sof = 0;
      end
      cur.err = geo_err | lines_differ();
      cur.valid = in_frame;
      cur.pix = p; cur.de = d; cur.hs = h; cur.vs = v;
    end
    exp_q.push_back(cur);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pixel", int'(pixel_o), e.pix);
        chk("de", int'(de_o), int'(e.de));
        chk("h_sync", int'(h_sync_o), int'(e.hs));
        chk("v_sync", int'(v_sync_o), int'(e.vs));
        chk("valid", int'(valid_o), int'(e.valid));
        chk("sof", int'(sof_o), int'(e.sof));
        chk("eol", int'(eol_o), int'(e.eol));
        chk("eof", int'(eof_o), int'(e.eof));
        chk("err", int'(err_o), int'(e.err));
        chk("x", int'(x_o), e.x);
        chk("y", int'(y_o), e.y);
        chk("frame_w", int'(frame_w_o), e.fw);
        chk("frame_h", int'(frame_h_o), e.fh);
`ifdef VIDEO_CTX_FRAME_CNT_EN
        chk("frame_cnt", int'(frame_cnt_o), e.fcnt);
`endif
      end
    end
  end

  task automatic cyc(input bit r, input bit c, input bit d, input bit h, input bit v);
    @(negedge clk);
    rst = r; ce = c; de_i = d; h_sync_i = h; v_sync_i = v;
    pixel_i = 24'($urandom);
    model_step(r, c, int'(pixel_i), d, h, v);
  endtask

  task automatic step(input bit d, input bit h, input bit v);
    if (jitter)
      while ($urandom_range(0, 3) == 0)
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b1, d, h, v);
  endtask

  task automatic run_line(input int len, input int blank);
    for (int i = 0; i < len; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < blank; i++) step(1'b0, i == 0, 1'b0);
  endtask

  task automatic vsync();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int w, input int h);
    for (int i = 0; i < h; i++) run_line(w, 2);
    vsync();
  endtask

  initial begin
    int w, h;
    model_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Video before any v_sync: pass-through only.
    run_line(5, 2);
    run_line(3, 2);
    vsync();
    frame(4, 3);

    // Line lengths 4,4,3 raise a sticky error cleared by the next v_sync.
    run_line(4, 2); run_line(4, 2); run_line(3, 2);
    vsync();

    // Same 4x3 frame with ce stalls sprinkled in.
    jitter = 1'b1;
    frame(4, 3);

    // Last line ends in the same cycle as the v_sync edge.
    run_line(4, 2); run_line(4, 2); run_line(4, 0);
    vsync();

    // First pixel of a line coincides with the v_sync edge.
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    run_line(3, 2);
    vsync();

    // Zero-line frame.
    vsync();

    // Reset mid-line at x=2,y=1 while ce is low.
    run_line(4, 2);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    vsync();
    frame(4, 3);

    // Geometry change between completed frames.
    frame(4, 3);
    frame(4, 3);
    frame(5, 3);

    repeat (6) begin
      w = $urandom_range(1, 7);
      h = $urandom_range(0, 4);
      for (int i = 0; i < h; i++)
        run_line(($urandom_range(0, 4) == 0) ? w + 1 : w, $urandom_range(1, 3));
      vsync();
    end

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_ctx_tracker.md
Name: video_ctx_tracker

Overview:
- Front-end stage of the skin-detection pixel pipeline.
- Takes the raw video stream (pixel, de, h_sync, v_sync) and registers it once.
- Generates the pixel context (x/y coordinates, start-of-frame, end-of-line, end-of-frame, frame geometry, line-length error) that downstream del_x_x delay lines align with the processing latency of the filter stages.

Parameters:
- width, 24, pixel data width in bits.
- x_bits, 11, width of the column counter and the measured-width output.
- y_bits, 11, width of the row counter and the measured-height output.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; every register holds when ce=0.
- pixel_i  in  width  input pixel data.
- de_i  in  1  data enable (active pixel).
- h_sync_i  in  1  horizontal sync, active-high.
- v_sync_i  in  1  vertical sync, active-high.
- pixel_o  out  width  pixel_i delayed by 1 ce cycle.
- de_o / h_sync_o / v_sync_o  out  1 each  inputs delayed by 1 ce cycle.
- x_o  out  x_bits  column of the current de_o pixel (0-based).
- y_o  out  y_bits  row of the current de_o pixel (0-based).
- sof_o  out  1  high with the first de_o pixel of a frame.
- eol_o  out  1  1-cycle pulse on the first cycle after de_o falls.
- eof_o  out  1  1-cycle pulse coincident with the v_sync_o rising edge while in ST_FRAME.
- valid_o  out  1  high while in ST_FRAME (context trustworthy).
- frame_w_o  out  x_bits  pixels per line of the last completed frame.
- frame_h_o  out  y_bits  lines of the last completed frame.
- err_o  out  1  sticky line-length mismatch within the current frame.

Behaviour:
- Clocking: all state is updated on posedge clk only when ce=1, except rst. rst has priority over ce and acts even when ce=0.
- Reset values: every output is 0. State is ST_WAIT. Internal edge registers are 0.
- Latency: 1 ce cycle, input to every output. Context outputs are aligned to pixel_o/de_o.
- Edge detection: compare each input against its registered copy (de_o, v_sync_o).
  - v_rise = v_sync_i & ~v_sync_o.
  - de_fall = ~de_i & de_o.
  - de_rise = de_i & ~de_o.
- FSM:
  - ST_WAIT: pass-through only. x/y counters stay 0. sof_o, eol_o, eof_o and err_o stay 0. On v_rise, go to ST_FRAME and clear the counters. No eof_o is issued on this edge.
  - ST_FRAME: on v_rise, pulse eof_o and latch the measured geometry into frame_w_o/frame_h_o. Then clear y_cnt, x_cnt, first_line, err and ref_w. Remain in ST_FRAME.
- Counters:
  - x_o = x_cnt while de_i=1; x_cnt increments per de pixel and clears on de_fall.
  - y_cnt increments on each de_fall. y_o is presented during de.
  - Counters saturate at all-ones; they do not wrap.
- sof_o: asserted when de_rise, y_cnt==0 and the state is ST_FRAME.
- Line-length check:
  - On the first de_fall of a frame, store the line length in ref_w.
  - On each later de_fall, if the length differs from ref_w, set err_o.
  - err_o holds until the next v_rise or rst.
- Frame geometry:
  - frame_w_o = ref_w.
  - frame_h_o = y_cnt at v_rise. If a de_fall occurs in the same cycle, it is counted first.
- Simultaneous events:
  - v_rise together with de_fall: the line is counted and checked first, then the frame is closed.
  - v_rise together with de_rise: the pixel becomes x=0, y=0 of the new frame and sof_o=1.
- Zero-line frame (v_rise with no de since the last v_rise): eof_o still pulses and frame_h_o=0, frame_w_o=0.
- rst mid-line: outputs are 0 on the next cycle, the block returns to ST_WAIT, and the partial frame is discarded.
- h_sync_i is passed through only; it is not used for counting.

Optional Feature:
- Macro: VIDEO_CTX_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_o [15:0].
  - Resets to 0, increments on each eof_o and wraps 0xFFFF -> 0.
  - Also sets err_o when a frame's frame_w_o/frame_h_o differs from the previous completed frame.
  - This comparison is skipped for the first completed frame after reset.
- Undefined:
  - Port is absent, no counter logic is built.
  - err_o reflects only the intra-frame line-length check.

Decomposition:
- Shared package video_ctx_pkg:
  - FSM state encoding ST_WAIT/ST_FRAME.
  - Default x_bits/y_bits.
  - A context struct type {de, h_sync, v_sync, sof, eol, eof, x, y} so downstream stages can push it through del_x_x as one vector.
- Sub-module edge_det (registered rising/falling detector, ce-gated, sync reset).
  - Instantiated for v_sync and de.

Test Plan:
- Reset then a 4x3 frame (4 de cycles per line, 2 blank, 3 lines, v_sync before and after) -> first frame after v_rise:
  - sof_o on x=0,y=0.
  - x_o sequence 0,1,2,3 per line.
  - eol_o pulses 3 times.
  - Second v_rise gives eof_o=1, frame_w_o=4, frame_h_o=3, err_o=0.
- Data before the first v_sync -> valid_o=0, sof_o never asserted, pixel_o equals pixel_i delayed by 1 cycle.
- Line lengths 4,4,3 -> err_o rises the cycle after the 3rd de_fall and stays 1. It clears on the next v_rise.
- ce toggled 1,0,1,0 during a line -> x_o advances only on ce=1 cycles and all outputs hold while ce=0. Results match the ce=1 run.
- rst asserted mid-line (x=2,y=1) with ce=0 -> all outputs 0 next cycle, block in ST_WAIT; the following frame counts from x=0,y=0.
- VIDEO_CTX_FRAME_CNT_EN on two 4x3 frames followed by a 5x3 frame:
  - frame_cnt_o = 1, 2, 3 after each eof_o.
  - err_o set at the third eof_o (width changed from the previous frame).
